// File: rtl/ccff_loader_pkg.sv
// Shared types and helpers for the frac_lut6 configuration chain loader.
package ccff_loader_pkg;

  localparam int unsigned DEF_CHAIN_LEN = 65;
  localparam int unsigned DEF_WORD_W    = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_e;

  // Number of bits of the next word that still belong to the chain.
  function automatic int unsigned min_bits(input int unsigned rem, input int unsigned word_w);
    return (rem < word_w) ? rem : word_w;
  endfunction

endpackage

// File: rtl/ccff_word_serializer.sv
// MSB-first word shifter with a count of the word bits still to be shifted.
module ccff_word_serializer #(
  parameter int unsigned WORD_W = 8,
  parameter int unsigned WB_W   = $clog2(WORD_W + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              shift,
  input  logic [WORD_W-1:0] load_data,
  input  logic [WB_W-1:0]   load_bits,
  output logic              msb,
  output logic [WB_W-1:0]   wbits,
  output logic [WB_W-1:0]   wbits_nxt_c
);

  logic [WORD_W-1:0] shreg_q;

  // A reload on the last bit of a word takes priority over the shift.
  always_comb begin
    wbits_nxt_c = wbits;
    if (load) begin
      wbits_nxt_c = load_bits;
    end else if (shift) begin
      wbits_nxt_c = WB_W'(wbits - WB_W'(1));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shreg_q <= '0;
      wbits   <= '0;
    end else begin
      wbits <= wbits_nxt_c;
      if (load) begin
        shreg_q <= load_data;
      end else if (shift) begin
        shreg_q <= shreg_q << 1;
      end
    end
  end

  assign msb = shreg_q[WORD_W-1];

endmodule

// File: rtl/ccff_chain_loader.sv
// Loads or verifies a ccff configuration chain from host words, one bit per prog_clk.
module ccff_chain_loader
  import ccff_loader_pkg::*;
#(
  parameter int unsigned CHAIN_LEN = DEF_CHAIN_LEN,
  parameter int unsigned WORD_W    = DEF_WORD_W,
  parameter int unsigned CNT_W     = $clog2(CHAIN_LEN + 1)
) (
  input  logic              prog_clk,
  input  logic              pReset,
  input  logic              start,
  input  logic              verify,
  input  logic              abort,
  input  logic [WORD_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              ccff_head,
  output logic              shift_en,
  input  logic              ccff_tail,
  output logic              busy,
  output logic              done,
  output logic              mismatch,
  output logic [CNT_W-1:0]  err_idx
);

  localparam int unsigned WB_W = $clog2(WORD_W + 1);

  state_e           state_q;
  state_e           state_n;
  logic [CNT_W-1:0] bits_rem_q;
  logic [CNT_W-1:0] rem_n;
  logic [WB_W-1:0]  wbits;
  logic [WB_W-1:0]  wbits_nxt_c;
  logic [WB_W-1:0]  load_bits;
  logic             verify_q;
  logic             hs;
  logic             start_ok;
  logic             shift;
  logic             in_ready_n;
  logic             tail_err;

  assign hs = in_valid && in_ready;

  ccff_word_serializer #(
    .WORD_W (WORD_W),
    .WB_W   (WB_W)
  ) u_ser (
    .clk         (prog_clk),
    .rst         (pReset),
    .load        (hs),
    .shift       (shift),
    .load_data   (in_data),
    .load_bits   (load_bits),
    .msb         (ccff_head),
    .wbits       (wbits),
    .wbits_nxt_c (wbits_nxt_c)
  );

  always_ff @(posedge prog_clk) begin
    if (pReset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_n;
    end
  end

  // abort overrides every transition; a reloaded last bit keeps SHIFT bubble-free.
  always_comb begin
    state_n = state_q;
    unique case (state_q)
      IDLE:  if (start) state_n = FETCH;
      FETCH: if (hs) state_n = SHIFT;
      SHIFT: begin
        if (bits_rem_q == CNT_W'(1)) begin
          state_n = DONE;
        end else if (wbits == WB_W'(1) && !hs) begin
          state_n = FETCH;
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if (abort) state_n = IDLE;
  end

  // in_ready is precomputed for the coming cycle so it leaves a flop.
  always_comb begin
    start_ok = (state_q == IDLE) && start && !abort;
    shift    = (state_q == SHIFT);
    rem_n    = bits_rem_q;
    if (start_ok) begin
      rem_n = CNT_W'(CHAIN_LEN);
    end else if (shift) begin
      rem_n = CNT_W'(bits_rem_q - CNT_W'(1));
    end
    load_bits  = WB_W'(min_bits(32'(rem_n), WORD_W));
    in_ready_n = (state_n == FETCH) ||
                 ((state_n == SHIFT) && (wbits_nxt_c == WB_W'(1)) && (rem_n > CNT_W'(1)));
    tail_err   = shift && verify_q && !abort && (ccff_tail != ccff_head);
  end

  always_ff @(posedge prog_clk) begin
    if (pReset) begin
      bits_rem_q <= '0;
      verify_q   <= 1'b0;
      mismatch   <= 1'b0;
      err_idx    <= '0;
      shift_en   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      in_ready   <= 1'b0;
    end else begin
      bits_rem_q <= rem_n;
      shift_en   <= (state_n == SHIFT);
      busy       <= (state_n != IDLE);
      done       <= (state_n == DONE);
      in_ready   <= in_ready_n;
      if (start_ok) begin
        verify_q <= verify;
        mismatch <= 1'b0;
        err_idx  <= '0;
      end else if (tail_err) begin
        mismatch <= 1'b1;
        if (!mismatch) err_idx <= CNT_W'(CNT_W'(CHAIN_LEN) - bits_rem_q);
      end
    end
  end

  a_shift_busy: assert property (@(posedge prog_clk) disable iff (pReset) shift_en |-> busy);
  a_shift_state: assert property (@(posedge prog_clk) disable iff (pReset)
    (state_q == SHIFT) == shift_en);
  a_rem_live: assert property (@(posedge prog_clk) disable iff (pReset)
    (state_q == SHIFT) |-> (bits_rem_q != '0));
  a_done_idle: assert property (@(posedge prog_clk) disable iff (pReset) done |=> !busy);

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Randomized bench for ccff_chain_loader against a bit-stream model of the chain.
module tb_ccff_chain_loader;

  localparam int unsigned CL = 65;
  localparam int unsigned WW = 8;
  localparam int unsigned CW = 7;
  localparam int unsigned NW = 9;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, start, verify, abort, in_valid;
  logic [WW-1:0] in_data;
  logic          in_ready, ccff_head, shift_en, ccff_tail, busy, done, mismatch;
  logic [CW-1:0] err_idx;

  ccff_chain_loader #(.CHAIN_LEN(CL), .WORD_W(WW)) dut (
    .prog_clk(clk), .pReset(rst), .start(start), .verify(verify), .abort(abort),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready), .ccff_head(ccff_head),
    .shift_en(shift_en), .ccff_tail(ccff_tail), .busy(busy), .done(done),
    .mismatch(mismatch), .err_idx(err_idx)
  );

  logic       s8_start, s8_valid, s8_ready, s8_head, s8_shift, s8_busy, s8_done, s8_mm;
  logic [7:0] s8_data;
  logic [3:0] s8_err;

  ccff_chain_loader #(.CHAIN_LEN(8), .WORD_W(8)) dut8 (
    .prog_clk(clk), .pReset(rst), .start(s8_start), .verify(1'b0), .abort(1'b0),
    .in_data(s8_data), .in_valid(s8_valid), .in_ready(s8_ready), .ccff_head(s8_head),
    .shift_en(s8_shift), .ccff_tail(1'b0), .busy(s8_busy), .done(s8_done),
    .mismatch(s8_mm), .err_idx(s8_err)
  );

  // The driven chain: 65 flops shifting head toward tail.
  logic [CL-1:0] chain = '0;
  always @(posedge clk) if (shift_en) chain <= {chain[CL-2:0], ccff_head};
  assign ccff_tail = chain[CL-1];

  int   nsh = 0, nidle = 0, ndone = 0;
  logic bitlog [0:8191];
  always @(negedge clk) begin
    if (shift_en) begin
      if (nsh < 8192) bitlog[nsh] <= ccff_head;
      nsh <= nsh + 1;
    end else if (busy) begin
      nidle <= nidle + 1;
    end
    if (done) ndone <= ndone + 1;
  end

  int checks = 0, failures = 0;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  logic [WW-1:0] words     [NW];
  logic [WW-1:0] ref_words [NW];
  int            stall     [NW];
  logic [127:0]  ref_bits;
  logic [127:0]  r_bits;
  int            r_sh, r_idle, r_done, nhs, pass_base;
  logic          aborted;

  function automatic logic [127:0] stream_of();
    logic [127:0] s = '0;
    for (int k = 0; k < CL; k++) s[k] = words[k / WW][WW - 1 - (k % WW)];
    return s;
  endfunction

  function automatic int first_diff(input logic [127:0] d);
    for (int k = 0; k < CL; k++) if (d[k]) return k;
    return 0;
  endfunction

  task automatic flip_bit(input int k);
    words[k / WW][WW - 1 - (k % WW)] = ~words[k / WW][WW - 1 - (k % WW)];
  endtask

  // Host side: honours per-word stall counts, pokes junk valid while not ready.
  task automatic run_pass(input logic vfy);
    int b_idle, b_done, guard, skip;
    logic sent;
    b_idle = nidle; b_done = ndone; nhs = 0; aborted = 1'b0;
    @(negedge clk); start = 1'b1; verify = vfy;
    @(negedge clk); start = 1'b0; verify = 1'b0;
    for (int i = 0; i < NW && !aborted; i++) begin
      skip = stall[i]; sent = 1'b0; guard = 0;
      while (!sent && !aborted && guard < 200) begin
        if (!busy) begin
          aborted = 1'b1; in_valid = 1'b0;
        end else if (in_ready && skip == 0) begin
          in_valid = 1'b1; in_data = words[i]; nhs++; sent = 1'b1;
        end else begin
          if (in_ready) skip--;
          in_valid = 1'($urandom) & !in_ready;
          in_data  = WW'($urandom);
        end
        @(negedge clk); guard++;
      end
      if (guard >= 200) check_eq("word_timeout", 128'(guard), 128'(0));
    end
    guard = 0;
    while (busy && !aborted && guard < 300) begin
      if (in_ready) nhs++;
      in_valid = 1'b1; in_data = WW'($urandom);
      @(negedge clk); guard++;
    end
    in_valid = 1'b0;
    #1;
    check_eq("pass_end_busy", 128'(busy), 128'(0));
    r_sh = nsh - pass_base; r_idle = nidle - b_idle; r_done = ndone - b_done;
    r_bits = '0;
    for (int k = 0; k < CL; k++) r_bits[k] = bitlog[pass_base + k];
  endtask

  task automatic do_pass(input logic vfy);
    pass_base = nsh;
    run_pass(vfy);
  endtask

  task automatic check_pass(input logic vfy, input int exp_idle);
    logic [127:0] exp_bits, diff;
    int sum;
    exp_bits = stream_of();
    diff = vfy ? (exp_bits ^ ref_bits) : '0;
    check_eq("pass_bits", r_bits, exp_bits);
    check_eq("pass_shifts", 128'(r_sh), 128'(CL));
    check_eq("pass_gaps", 128'(r_idle), 128'(exp_idle));
    check_eq("pass_done", 128'(r_done), 128'(1));
    check_eq("pass_words", 128'(nhs), 128'(NW));
    check_eq("pass_mismatch", 128'(mismatch), 128'(diff != '0));
    check_eq("pass_err_idx", 128'(err_idx), 128'(first_diff(diff)));
    ref_bits = exp_bits; ref_words = words;
    sum = 0;
  endtask

  function automatic int gaps_expected();
    int s = 2;
    for (int i = 0; i < NW; i++) s += stall[i];
    return s;
  endfunction

  // Abort (kind 0) or reset (kind 1) after at_bit shifts; kind 0 also pokes start mid-pass.
  task automatic disturb(input int kind, input int at_bit);
    int g = 0;
    while ((nsh - pass_base) < 10 && g < 400) begin @(negedge clk); #1; g++; end
    if (kind == 0) begin start = 1'b1; @(negedge clk); #1; start = 1'b0; end
    while ((nsh - pass_base) < at_bit && g < 400) begin @(negedge clk); #1; g++; end
    if (kind == 0) abort = 1'b1; else rst = 1'b1;
    @(posedge clk); #1;
    check_eq("dist_busy", 128'(busy), 128'(0));
    check_eq("dist_shift_en", 128'(shift_en), 128'(0));
    check_eq("dist_in_ready", 128'(in_ready), 128'(0));
    check_eq("dist_done", 128'(done), 128'(0));
    if (kind == 1) begin
      check_eq("rst_head", 128'(ccff_head), 128'(0));
      check_eq("rst_mismatch", 128'(mismatch), 128'(0));
      check_eq("rst_err_idx", 128'(err_idx), 128'(0));
    end
    @(negedge clk); abort = 1'b0; rst = 1'b0;
  endtask

  task automatic random_words();
    for (int i = 0; i < NW; i++) begin
      words[i] = WW'($urandom);
      stall[i] = 0;
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

  initial begin
    logic [7:0] w8, got8;
    int n8, first8, last8, nbusy8, nrdy8, nd8;

    rst = 1'b1; start = 1'b0; verify = 1'b0; abort = 1'b0; in_valid = 1'b0; in_data = '0;
    s8_start = 1'b0; s8_valid = 1'b0; s8_data = '0;
    ref_bits = '0;
    for (int i = 0; i < NW; i++) stall[i] = 0;
    repeat (3) @(negedge clk);
    check_eq("rst_busy", 128'(busy), 128'(0));
    check_eq("rst_done", 128'(done), 128'(0));
    check_eq("rst_shift_en", 128'(shift_en), 128'(0));
    check_eq("rst_head0", 128'(ccff_head), 128'(0));
    check_eq("rst_in_ready", 128'(in_ready), 128'(0));
    check_eq("rst_mm0", 128'(mismatch), 128'(0));
    check_eq("rst_err0", 128'(err_idx), 128'(0));
    rst = 1'b0;
    @(negedge clk);

    // 0xA5 x8 + 0x80 streamed without gaps
    for (int i = 0; i < NW; i++) words[i] = 8'hA5;
    words[NW-1] = 8'h80;
    do_pass(1'b0); check_pass(1'b0, 2);
    do_pass(1'b1); check_pass(1'b1, 2);
    flip_bit(20); flip_bit(40);
    do_pass(1'b1); check_pass(1'b1, 2);
    check_eq("err_first_flip", 128'(err_idx), 128'(20));

    // Host stall of three ready cycles before word 3
    for (int i = 0; i < NW; i++) words[i] = 8'hA5;
    words[NW-1] = 8'h80;
    stall[3] = 3;
    do_pass(1'b0); check_pass(1'b0, 5);

    for (int it = 0; it < 10; it++) begin
      logic vfy;
      vfy = 1'($urandom);
      if (vfy) begin
        words = ref_words;
        for (int i = 0; i < NW; i++)
          if ($urandom_range(0, 3) == 0) words[i] = words[i] ^ (WW'(1) << $urandom_range(0, WW - 1));
      end else begin
        for (int i = 0; i < NW; i++) words[i] = WW'($urandom);
      end
      for (int i = 0; i < NW; i++)
        stall[i] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
      do_pass(vfy); check_pass(vfy, gaps_expected());
    end

    // Abort mid word 4 of a verify pass with an early error
    words = ref_words; flip_bit(5);
    for (int i = 0; i < NW; i++) stall[i] = 0;
    pass_base = nsh;
    fork
      run_pass(1'b1);
      disturb(0, 28);
    join
    check_eq("abort_no_done", 128'(r_done), 128'(0));
    check_eq("abort_mm_hold", 128'(mismatch), 128'(1));
    check_eq("abort_err_hold", 128'(err_idx), 128'(5));
    random_words(); do_pass(1'b0); check_pass(1'b0, 2);

    // start together with abort in IDLE stays idle
    @(negedge clk); start = 1'b1; abort = 1'b1;
    @(posedge clk); #1;
    check_eq("start_abort_busy", 128'(busy), 128'(0));
    check_eq("start_abort_ready", 128'(in_ready), 128'(0));
    @(negedge clk); start = 1'b0; abort = 1'b0;

    // Reset mid-SHIFT during a failing verify
    words = ref_words; flip_bit(3);
    pass_base = nsh;
    fork
      run_pass(1'b1);
      disturb(1, 15);
    join
    random_words(); do_pass(1'b0); check_pass(1'b0, 2);

    // Single-word chain: 8 shifts, one fetch, no bubble
    w8 = 8'($urandom);
    @(negedge clk); s8_start = 1'b1; s8_valid = 1'b1; s8_data = w8;
    @(negedge clk); s8_start = 1'b0;
    got8 = '0; n8 = 0; first8 = -1; last8 = -1; nbusy8 = 0; nrdy8 = 0; nd8 = 0;
    for (int c = 0; c < 30; c++) begin
      if (s8_shift) begin
        got8 = {got8[6:0], s8_head}; n8++;
        if (first8 < 0) first8 = c;
        last8 = c;
      end
      if (s8_busy) nbusy8++;
      if (s8_ready) nrdy8++;
      if (s8_done) nd8++;
      @(negedge clk);
    end
    s8_valid = 1'b0;
    check_eq("c8_bits", 128'(got8), 128'(w8));
    check_eq("c8_shifts", 128'(n8), 128'(8));
    check_eq("c8_contig", 128'(last8 - first8), 128'(7));
    check_eq("c8_busy", 128'(nbusy8), 128'(10));
    check_eq("c8_ready", 128'(nrdy8), 128'(1));
    check_eq("c8_done", 128'(nd8), 128'(1));
    check_eq("c8_mm", 128'(s8_mm), 128'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
